// File: rtl/endgame_pkg.sv
// Shared types and constants for the Pong end-of-game sequencer:
// FSM encoding, player IDs, screen size and default banner geometry.
package endgame_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_SLIDE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P1     = 2'd1;
  localparam logic [1:0] P2     = 2'd2;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int DEF_BANNER_X = 240;
  localparam int DEF_START_Y  = 0;
  localparam int DEF_FINAL_Y  = 200;

endpackage

// File: rtl/endgame_frame_timer.sv
// Frame-based hold and blink timers for the HOLD phase; held at zero while
// clear is high so that every HOLD entry starts from a fresh count.
module endgame_frame_timer
  import endgame_pkg::*;
#(
  parameter int HOLD_FRAMES  = 180,
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic frame_tick,
  output logic hold_done,
  output logic blink_toggle
);

  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt_r, frame_cnt_s;
  logic [BW-1:0] blink_cnt_r, blink_cnt_s;
  logic          blink_wrap_s;

  // Next-count logic: saturating hold counter, wrapping blink counter.
  always_comb begin
    frame_cnt_s  = frame_cnt_r;
    blink_cnt_s  = blink_cnt_r;
    blink_wrap_s = (blink_cnt_r == BW'(BLINK_FRAMES - 1));
    if (clear) begin
      frame_cnt_s = '0;
      blink_cnt_s = '0;
    end else if (frame_tick) begin
      if (frame_cnt_r != FW'(HOLD_FRAMES)) begin
        frame_cnt_s = frame_cnt_r + FW'(1);
      end else begin
        frame_cnt_s = frame_cnt_r;
      end
      if (blink_wrap_s) begin
        blink_cnt_s = '0;
      end else begin
        blink_cnt_s = blink_cnt_r + BW'(1);
      end
    end else begin
      frame_cnt_s = frame_cnt_r;
      blink_cnt_s = blink_cnt_r;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= '0;
      blink_cnt_r <= '0;
    end else begin
      frame_cnt_r <= frame_cnt_s;
      blink_cnt_r <= blink_cnt_s;
    end
  end

  assign hold_done    = (frame_cnt_r == FW'(HOLD_FRAMES));
  assign blink_toggle = frame_tick & ~clear & blink_wrap_s;

endmodule

// File: rtl/endgame_controller.sv
// Pong game-over sequencer: scores points, detects the winner, slides and
// blinks the end banner, then waits for a released restart to resume play.
module endgame_controller
  import endgame_pkg::*;
#(
  parameter int WIN_SCORE    = 5,
  parameter int BANNER_X     = DEF_BANNER_X,
  parameter int START_Y      = DEF_START_Y,
  parameter int FINAL_Y      = DEF_FINAL_Y,
  parameter int SLIDE_STEP   = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       restart,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] who_win,
  output logic [9:0] start_x,
  output logic [9:0] start_y,
  output logic       show_endgame,
  output logic       banner_on,
  output logic       game_run
);

  state_t      state_r, state_s;
  logic [3:0]  score1_r, score1_s, score2_r, score2_s;
  logic [1:0]  who_win_r, who_win_s;
  logic [9:0]  start_x_r, start_y_r, start_y_s;
  logic        show_r, show_s, banner_r, banner_s, run_r, run_s;
  logic [10:0] slide_sum_s;
  logic        hold_done_s, blink_toggle_s;

  endgame_frame_timer #(
    .HOLD_FRAMES (HOLD_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (state_r != ST_HOLD),
    .frame_tick  (frame_tick),
    .hold_done   (hold_done_s),
    .blink_toggle(blink_toggle_s)
  );

  // 11-bit sum so the slide can never wrap past 1023.
  assign slide_sum_s = {1'b0, start_y_r} + 11'(SLIDE_STEP);

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    score1_s  = score1_r;
    score2_s  = score2_r;
    who_win_s = who_win_r;
    start_y_s = start_y_r;
    show_s    = show_r;
    banner_s  = banner_r;
    run_s     = run_r;
    case (state_r)
      ST_PLAY: begin
        if (p1_point && (score1_r != 4'(WIN_SCORE))) begin
          score1_s = score1_r + 4'd1;
        end else begin
          score1_s = score1_r;
        end
        if (p2_point && (score2_r != 4'(WIN_SCORE))) begin
          score2_s = score2_r + 4'd1;
        end else begin
          score2_s = score2_r;
        end
        // Player 1 has fixed priority on a simultaneous win.
        if (score1_s == 4'(WIN_SCORE)) begin
          who_win_s = P1;
          run_s     = 1'b0;
          show_s    = 1'b1;
          start_y_s = 10'(START_Y);
          state_s   = ST_SLIDE;
        end else if (score2_s == 4'(WIN_SCORE)) begin
          who_win_s = P2;
          run_s     = 1'b0;
          show_s    = 1'b1;
          start_y_s = 10'(START_Y);
          state_s   = ST_SLIDE;
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_SLIDE: begin
        banner_s = 1'b1;
        if (frame_tick) begin
          if (slide_sum_s >= 11'(FINAL_Y)) begin
            start_y_s = 10'(FINAL_Y);
            state_s   = ST_HOLD;
          end else begin
            start_y_s = slide_sum_s[9:0];
          end
        end else begin
          state_s = ST_SLIDE;
        end
      end
      ST_HOLD: begin
        if (restart && hold_done_s) begin
          banner_s = 1'b1;
          state_s  = ST_CLEAR;
        end else if (blink_toggle_s) begin
          banner_s = ~banner_r;
        end else begin
          banner_s = banner_r;
        end
      end
      ST_CLEAR: begin
        // Resume only once the button is released, so a held press cannot retrigger.
        if (!restart) begin
          score1_s  = 4'd0;
          score2_s  = 4'd0;
          who_win_s = P_NONE;
          show_s    = 1'b0;
          start_y_s = 10'(START_Y);
          run_s     = 1'b1;
          state_s   = ST_PLAY;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      default: begin
        state_s = ST_PLAY;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_PLAY;
      score1_r  <= 4'd0;
      score2_r  <= 4'd0;
      who_win_r <= P_NONE;
      start_x_r <= 10'(BANNER_X);
      start_y_r <= 10'(START_Y);
      show_r    <= 1'b0;
      banner_r  <= 1'b1;
      run_r     <= 1'b1;
    end else begin
      state_r   <= state_s;
      score1_r  <= score1_s;
      score2_r  <= score2_s;
      who_win_r <= who_win_s;
      start_x_r <= 10'(BANNER_X);
      start_y_r <= start_y_s;
      show_r    <= show_s;
      banner_r  <= banner_s;
      run_r     <= run_s;
    end
  end

  assign score1       = score1_r;
  assign score2       = score2_r;
  assign who_win      = who_win_r;
  assign start_x      = start_x_r;
  assign start_y      = start_y_r;
  assign show_endgame = show_r;
  assign banner_on    = banner_r;
  assign game_run     = run_r;

endmodule

// File: tb/tb_endgame_controller.sv
// Directed self-checking bench for endgame_controller using small test
// parameters (win at 3, 50-pixel slide steps, 2-frame blink, 4-frame hold).
module tb_endgame_controller;
  import endgame_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] score1, score2;
  logic [1:0] who_win;
  logic [9:0] start_x, start_y;
  logic       show_endgame, banner_on, game_run;

  int n_checks = 0;
  int n_fail   = 0;

  endgame_controller #(
    .WIN_SCORE(3), .BANNER_X(240), .START_Y(0), .FINAL_Y(200),
    .SLIDE_STEP(50), .BLINK_FRAMES(2), .HOLD_FRAMES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .p1_point(p1_point), .p2_point(p2_point), .restart(restart),
    .score1(score1), .score2(score2), .who_win(who_win),
    .start_x(start_x), .start_y(start_y), .show_endgame(show_endgame),
    .banner_on(banner_on), .game_run(game_run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic f, input logic a, input logic b);
    @(negedge clk);
    frame_tick = f;
    p1_point   = a;
    p2_point   = b;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    p1_point   = 1'b0;
    p2_point   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_score1"}, 32'(score1), 32'd0);
    chk({tag, "_score2"}, 32'(score2), 32'd0);
    chk({tag, "_who_win"}, 32'(who_win), 32'd0);
    chk({tag, "_start_x"}, 32'(start_x), 32'd240);
    chk({tag, "_start_y"}, 32'(start_y), 32'd0);
    chk({tag, "_show"}, 32'(show_endgame), 32'd0);
    chk({tag, "_banner"}, 32'(banner_on), 32'd1);
    chk({tag, "_game_run"}, 32'(game_run), 32'd1);
    chk({tag, "_state"}, 32'(dut.state_r), 32'(ST_PLAY));
  endtask

  initial begin
    int ys [4];
    ys = '{50, 100, 150, 200};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: player 1 scores three times
    for (int i = 1; i <= 3; i++) begin
      idle(9);
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("s1_score1_%0d", i), 32'(score1), 32'(i));
      chk($sformatf("s1_who_%0d", i), 32'(who_win), (i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("s1_run_%0d", i), 32'(game_run), (i == 3) ? 32'd0 : 32'd1);
      chk($sformatf("s1_show_%0d", i), 32'(show_endgame), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("s1_state", 32'(dut.state_r), 32'(ST_SLIDE));
    chk("s1_start_y", 32'(start_y), 32'd0);

    // Scenario 5a: point pulse in SLIDE is dropped
    step(1'b0, 1'b0, 1'b1);
    chk("s5_slide_score2", 32'(score2), 32'd0);

    // Scenario 2: slide down in 50-pixel steps
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("s2_y_%0d", i), 32'(start_y), 32'(ys[i]));
      chk($sformatf("s2_banner_%0d", i), 32'(banner_on), 32'd1);
      chk($sformatf("s2_state_%0d", i), 32'(dut.state_r),
          (i == 3) ? 32'(ST_HOLD) : 32'(ST_SLIDE));
    end
    step(1'b1, 1'b0, 1'b0);
    chk("s2_y_5th", 32'(start_y), 32'd200);
    chk("s2_banner_5th", 32'(banner_on), 32'd1);
    chk("s2_state_5th", 32'(dut.state_r), 32'(ST_HOLD));

    // Scenario 5b: point pulse in HOLD is dropped
    step(1'b0, 1'b0, 1'b1);
    chk("s5_hold_score2", 32'(score2), 32'd0);

    // Scenario 4: hold timer, blink, early restart ignored
    step(1'b1, 1'b0, 1'b0);
    chk("s4_banner_t2", 32'(banner_on), 32'd0);
    restart = 1'b1;
    idle(2);
    restart = 1'b0;
    chk("s4_early_restart", 32'(dut.state_r), 32'(ST_HOLD));
    step(1'b1, 1'b0, 1'b0);
    chk("s4_banner_t3", 32'(banner_on), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("s4_banner_t4", 32'(banner_on), 32'd1);
    idle(2);
    chk("s4_no_latch", 32'(dut.state_r), 32'(ST_HOLD));
    restart = 1'b1;
    idle(1);
    chk("s4_clear", 32'(dut.state_r), 32'(ST_CLEAR));
    chk("s4_clear_banner", 32'(banner_on), 32'd1);
    idle(3);
    chk("s4_clear_held", 32'(dut.state_r), 32'(ST_CLEAR));
    chk("s4_clear_held_score1", 32'(score1), 32'd3);
    chk("s4_clear_held_who", 32'(who_win), 32'd1);
    restart = 1'b0;
    idle(1);
    chk_reset_vals("s4_release");

    // Scenario 3: simultaneous win from 2-2, player 1 has priority
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("s3_score1_2", 32'(score1), 32'd2);
    chk("s3_score2_2", 32'(score2), 32'd2);
    chk("s3_who_none", 32'(who_win), 32'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("s3_score1_3", 32'(score1), 32'd3);
    chk("s3_score2_3", 32'(score2), 32'd3);
    chk("s3_who_p1", 32'(who_win), 32'd1);
    chk("s3_state", 32'(dut.state_r), 32'(ST_SLIDE));

    // Scenario 6: asynchronous reset mid-slide
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("s6_y_100", 32'(start_y), 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("s6_async");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    chk("s6_after_score2", 32'(score2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/endgame_controller.md
Name: endgame_controller

Overview:
Game-over sequencer for the Pong VGA pipeline. It tracks both players' scores from point pulses and detects the winner. It then freezes play and animates the end-of-game banner by sliding it down and blinking it, driving the banner renderer's who_win, start_x and start_y inputs and its visibility gating. After a minimum hold time, a restart request clears the scores and returns to play.

Parameters:
WIN_SCORE, 5, points needed to win (1..15)
BANNER_X, 240, fixed banner start_x (pixels)
START_Y, 0, banner start_y when the slide begins
FINAL_Y, 200, banner resting start_y
SLIDE_STEP, 4, pixels moved per frame_tick while sliding
BLINK_FRAMES, 30, frame_ticks per blink half-period
HOLD_FRAMES, 180, frame_ticks in HOLD before restart is honoured

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  reset, asynchronous assert, active-low
frame_tick  in  1  one-cycle pulse per video frame (vsync edge)
p1_point  in  1  one-cycle pulse: player 1 scored
p2_point  in  1  one-cycle pulse: player 2 scored
restart  in  1  debounced, synchronous level from the restart button
score1  out  4  player 1 score
score2  out  4  player 2 score
who_win  out  2  0 = none, 1 = player 1, 2 = player 2
start_x  out  10  banner x origin (constant BANNER_X)
start_y  out  10  banner y origin
show_endgame  out  1  banner region active
banner_on  out  1  blink gate; the renderer ANDs it with its pixel hits
game_run  out  1  ball/paddle update enable

Behaviour:
- All outputs are registered.
- Values in reset:
  - state = PLAY
  - score1 = score2 = 0
  - who_win = 0
  - start_x = BANNER_X
  - start_y = START_Y
  - show_endgame = 0
  - banner_on = 1
  - game_run = 1
  - internal counters = 0
- States: PLAY, SLIDE, HOLD, CLEAR. The encoding comes from the package.
- PLAY:
  - Each point pulse increments its score on the same edge. Scores saturate at WIN_SCORE.
  - If the next score1 == WIN_SCORE, then on the same edge: who_win <= 1, game_run <= 0, show_endgame <= 1, start_y <= START_Y, state <= SLIDE. Otherwise the same applies with who_win <= 2 when the next score2 == WIN_SCORE.
  - If both pulses arrive in one cycle, both scores increment. If both reach WIN_SCORE together, player 1 wins (fixed priority).
- SLIDE:
  - On each frame_tick, start_y <= min(start_y + SLIDE_STEP, FINAL_Y). Use 11-bit intermediate arithmetic, so there is no wrap.
  - When start_y reaches FINAL_Y, go to HOLD on the same edge, with frame_cnt <= 0 and blink_cnt <= 0.
  - banner_on = 1 throughout. Point pulses and restart are ignored.
- HOLD:
  - On each frame_tick, frame_cnt increments, saturating at HOLD_FRAMES.
  - On each frame_tick, blink_cnt increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and banner_on toggles.
  - restart == 1 while frame_cnt == HOLD_FRAMES causes state <= CLEAR and banner_on <= 1.
  - restart before the hold expires is ignored; it does not latch.
- CLEAR:
  - Wait for restart == 0. On the edge where restart is seen low:
    - score1 = score2 = 0
    - who_win = 0
    - show_endgame = 0
    - start_y = START_Y
    - game_run = 1
    - state = PLAY
  - This prevents a held button from re-triggering.
- Point pulses outside PLAY are dropped.
- frame_tick and a point pulse arriving in the same cycle are independent; no interaction.
- Asserting rst_n low at any state immediately forces the values in reset above.
- start_x is constant BANNER_X in every state.

Decomposition:
- Package endgame_pkg holds:
  - the state encoding
  - the player IDs (P_NONE = 0, P1 = 1, P2 = 2)
  - the screen constants (H_ACTIVE = 640, V_ACTIVE = 480)
  - the default banner geometry
- One natural sub-module, endgame_frame_timer, holds frame_cnt and blink_cnt:
  - inputs: clk, rst_n, clear, frame_tick
  - outputs: hold_done, blink_toggle

Test Plan:
- Overrides for all scenarios: WIN_SCORE=3, SLIDE_STEP=50, START_Y=0, FINAL_Y=200, BLINK_FRAMES=2, HOLD_FRAMES=4.
- Scenario 1: after reset, 3 p1_point pulses 10 cycles apart -> score1 = 1, 2, 3. On the 3rd pulse's edge, who_win = 1, game_run = 0, show_endgame = 1, state SLIDE.
- Scenario 2: in SLIDE, 5 frame_ticks -> start_y = 50, 100, 150, 200. State becomes HOLD on the 4th tick. The 5th tick goes to the HOLD timers. banner_on stays 1 throughout the slide.
- Scenario 3: score 2–2, then p1_point and p2_point in the same cycle -> scores 3/3 and who_win = 1.
- Scenario 4: in HOLD, restart = 1 after 2 frame_ticks -> ignored. banner_on toggles every 2 ticks. restart after 4 ticks -> CLEAR. Holding restart keeps CLEAR. Releasing it -> scores 0, who_win 0, game_run 1, start_y 0, PLAY.
- Scenario 5: p2_point pulses during SLIDE and HOLD -> score2 unchanged.
- Scenario 6: rst_n pulsed low mid-SLIDE (start_y = 100) -> all outputs return to their values in reset asynchronously, without waiting for a clk edge.
